// File: rtl/kyber_enc_pkg.sv
// Shared constants, state encoding and helpers for the ByteEncode_d streaming stage.
package kyber_enc_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 12;
  localparam int MAX_D   = 12;
  localparam int ACC_W   = MAX_D + 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } enc_state_t;

  // 32*d bytes per polynomial; 384 at d=12 still fits the 9-bit byte counter.
  function automatic logic [8:0] bytes_per_poly(input logic [3:0] d);
    return {d, 5'b0_0000};
  endfunction

endpackage

// File: rtl/byte_encode_stream_bit_accumulator.sv
// LSB-first bit accumulator: inserts d-bit coefficients at the fill level and
// retires whole bytes from the bottom, shift applied before insert.
module bit_accumulator
  import kyber_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [3:0]        d,
  input  logic              ins,
  input  logic [COEF_W-1:0] coef,
  input  logic              shift,
  output logic [7:0]        low_byte,
  output logic [4:0]        cnt
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] coef_bits;
  logic [4:0]       cnt_base;
  logic [4:0]       cnt_next;

  // The byte shift lands first so the new coefficient goes in at the post-shift level.
  always_comb begin
    acc_base  = shift ? (acc >> 8) : acc;
    cnt_base  = shift ? (cnt - 5'd8) : cnt;
    coef_bits = ACC_W'(coef) & ((ACC_W'(1) << d) - ACC_W'(1));
    acc_next  = acc_base;
    cnt_next  = cnt_base;
    if (ins) begin
      acc_next = acc_base | (coef_bits << cnt_base);
      cnt_next = cnt_base + {1'b0, d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

  assign low_byte = acc[7:0];

endmodule

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d: packs 256 d-bit coefficients LSB-first into 32*d bytes
// with valid/ready on both sides; d is latched per polynomial at start.
module byte_encode_stream
  import kyber_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        d_in,
  output logic              busy,
  output logic              err,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  output logic              done
);

  enc_state_t state;
  enc_state_t state_next;
  logic [3:0] d_reg;
  logic [8:0] coef_cnt;
  logic [8:0] byte_cnt;
  logic [4:0] acc_cnt;
  logic [7:0] acc_byte;
  logic       d_legal;
  logic       start_ok;
  logic       coef_fire;
  logic       byte_fire;
  logic       err_q;

  assign d_legal    = (d_in != 4'd0) && (d_in <= 4'(MAX_D));
  assign start_ok   = (state == IDLE) && start && d_legal;
  assign coef_ready = (state == RUN) && (coef_cnt < 9'(KYBER_N)) && (acc_cnt < 5'd8);
  assign byte_valid = (state == RUN) && (acc_cnt >= 5'd8);
  assign byte_data  = acc_byte;
  assign byte_last  = byte_valid && (byte_cnt == bytes_per_poly(d_reg) - 9'd1);
  assign coef_fire  = coef_valid && coef_ready;
  assign byte_fire  = byte_valid && byte_ready;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign err        = err_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (byte_fire && byte_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Starts arriving outside IDLE are ignored entirely: no err and no relatch of d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      d_reg    <= '0;
      coef_cnt <= '0;
      byte_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= (state == IDLE) && start && !d_legal;
      if (start_ok) begin
        d_reg    <= d_in;
        coef_cnt <= '0;
        byte_cnt <= '0;
      end else begin
        if (coef_fire) coef_cnt <= coef_cnt + 9'd1;
        if (byte_fire) byte_cnt <= byte_cnt + 9'd1;
      end
    end
  end

  bit_accumulator u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .d        (d_reg),
    .ins      (coef_fire),
    .coef     (coef),
    .shift    (byte_fire),
    .low_byte (acc_byte),
    .cnt      (acc_cnt)
  );

endmodule
